// File: rtl/bit_serializer_pkg.sv
// Shared types and constants for the bit_serializer slice.
//   state_e   : serializer FSM states (IDLE, SHIFT, PAR, GAP)
//   GAP_CNT_W : width of the inter-word gap counter
package bit_serializer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2,
        GAP   = 2'd3
    } state_e;

    localparam int GAP_CNT_W = 4;

endpackage

// File: rtl/bit_serializer_hold_reg.sv
// serializer_hold_reg: one-word holding register in front of the shifter.
// Ports:
//   clk, reset     : clock, asynchronous active-low reset
//   in_data_i      : word offered by the producer
//   in_valid_i     : producer has a word
//   load_i         : shifter consumes the held word this edge
//   in_ready_o     : register empty, a word may be transferred
//   hold_full_o    : register holds a word
//   hold_data_o    : held word
// Handshake: a word transfers on a posedge where in_valid_i && in_ready_o;
// in_ready_o depends only on registered state, never on in_valid_i.
module serializer_hold_reg
    import bit_serializer_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data_i,
    input  logic             in_valid_i,
    input  logic             load_i,
    output logic             in_ready_o,
    output logic             hold_full_o,
    output logic [WIDTH-1:0] hold_data_o
);

    logic             full_q, full_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             take;

    assign take        = in_valid_i & ~full_q;
    assign in_ready_o  = ~full_q;
    assign hold_full_o = full_q;
    assign hold_data_o = data_q;

    // A consume and a capture on the same edge leave the register full with
    // the new word: the shifter has already taken the old contents.
    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (load_i) begin
            full_d = 1'b0;
        end
        if (take) begin
            full_d = 1'b1;
            data_d = in_data_i;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

endmodule

// File: rtl/bit_serializer.sv
// bit_serializer: parallel-to-serial front end for the bit-pattern detector.
// Words arrive on a valid/ready handshake, are shifted out one bit per
// bit_en slot on a registered data_out, optionally followed by an even
// parity slot and IDLE_GAP zero slots.
// Optional feature macro: SERIALIZER_PARITY_EN (compiles in the PAR state).
// Ports:
//   clk, reset : clock, asynchronous active-low reset
//   in_data    : word to send        in_valid : in_data valid
//   in_ready   : holding register empty
//   bit_en     : slot strobe, serial output advances only when 1
//   data_out   : registered serial bit
//   out_valid  : data_out carries a data or parity bit
//   busy       : FSM active or holding register full
//   word_done  : one-cycle pulse after the last slot of a word
//   dbg_state  : current FSM state (state_e encoding)
module bit_serializer
    import bit_serializer_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter int IDLE_GAP  = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             bit_en,
    output logic             data_out,
    output logic             out_valid,
    output logic             busy,
    output logic             word_done,
    output logic [1:0]       dbg_state
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]     LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [GAP_CNT_W-1:0] LAST_GAP = GAP_CNT_W'(IDLE_GAP - 1);

    state_e                 state_q, state_d;
    logic [WIDTH-1:0]       shift_q, shift_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [GAP_CNT_W-1:0]   gap_q, gap_d;
    logic                   dout_q, dout_d;
    logic                   oval_q, oval_d;
    logic                   done_q, done_d;
`ifdef SERIALIZER_PARITY_EN
    logic                   par_q, par_d;
`endif

    logic             hold_full;
    logic [WIDTH-1:0] hold_data;
    logic             load;
    logic             after_payload;
    logic             enter_gap;
    logic             finish;
    logic [WIDTH-1:0] shifted;

    serializer_hold_reg #(.WIDTH(WIDTH)) u_hold (
        .clk        (clk),
        .reset      (reset),
        .in_data_i  (in_data),
        .in_valid_i (in_valid),
        .load_i     (load),
        .in_ready_o (in_ready),
        .hold_full_o(hold_full),
        .hold_data_o(hold_data)
    );

    function automatic logic lead_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    // The bit on the wire is always the lead bit of shift_q.
    assign shifted = MSB_FIRST ? (shift_q << 1) : (shift_q >> 1);

    always_comb begin
        state_d       = state_q;
        shift_d       = shift_q;
        cnt_d         = cnt_q;
        gap_d         = gap_q;
        dout_d        = dout_q;
        oval_d        = oval_q;
        done_d        = 1'b0;
        load          = 1'b0;
        after_payload = 1'b0;
        enter_gap     = 1'b0;
        finish        = 1'b0;
`ifdef SERIALIZER_PARITY_EN
        par_d         = par_q;
`endif
        case (state_q)
            IDLE: begin
                // Start of a word does not wait for a slot strobe.
                load = hold_full;
            end
            SHIFT: begin
                if (bit_en) begin
                    if (cnt_q != LAST_CNT) begin
                        shift_d = shifted;
                        cnt_d   = cnt_q + CNT_W'(1);
                        dout_d  = lead_bit(shifted);
                    end else begin
`ifdef SERIALIZER_PARITY_EN
                        state_d = PAR;
                        dout_d  = par_q;
                        oval_d  = 1'b1;
`else
                        after_payload = 1'b1;
`endif
                    end
                end
            end
`ifdef SERIALIZER_PARITY_EN
            PAR: begin
                if (bit_en) begin
                    after_payload = 1'b1;
                end
            end
`endif
            GAP: begin
                if (bit_en) begin
                    if (gap_q == LAST_GAP) begin
                        finish = 1'b1;
                    end else begin
                        gap_d = gap_q + GAP_CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (after_payload) begin
            if (IDLE_GAP > 0) begin
                enter_gap = 1'b1;
            end else begin
                finish = 1'b1;
            end
        end

        if (enter_gap) begin
            state_d = GAP;
            gap_d   = '0;
            dout_d  = 1'b0;
            oval_d  = 1'b0;
        end

        if (finish) begin
            done_d = 1'b1;
            if (hold_full) begin
                // Reload on the finishing edge: no dead slot between words.
                load = 1'b1;
            end else begin
                state_d = IDLE;
                cnt_d   = '0;
                dout_d  = 1'b0;
                oval_d  = 1'b0;
            end
        end

        if (load) begin
            state_d = SHIFT;
            shift_d = hold_data;
            cnt_d   = '0;
            gap_d   = '0;
            dout_d  = lead_bit(hold_data);
            oval_d  = 1'b1;
`ifdef SERIALIZER_PARITY_EN
            par_d   = ^hold_data;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            gap_q   <= '0;
            dout_q  <= 1'b0;
            oval_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            dout_q  <= dout_d;
            oval_q  <= oval_d;
            done_q  <= done_d;
`ifdef SERIALIZER_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign data_out  = dout_q;
    assign out_valid = oval_q;
    assign word_done = done_q;
    assign busy      = (state_q != IDLE) | hold_full;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer. Two instances share the stimulus:
//   u0: MSB first, no gap;  u1: LSB first, IDLE_GAP=2.
// A slot-list model predicts every output each cycle; literal checks pin
// the model against hand-computed bit streams.
module tb_bit_serializer;

`ifdef SERIALIZER_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic       clk;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;
  logic       bit_en;
  logic [1:0] d_rdy, d_dout, d_oval, d_busy, d_done;
  logic [1:0] d_st0, d_st1;

  int n_vec = 0;
  int n_err = 0;
  logic check_en = 1'b0;

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_GAP(0)) u0 (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(d_rdy[0]), .bit_en(bit_en), .data_out(d_dout[0]),
    .out_valid(d_oval[0]), .busy(d_busy[0]), .word_done(d_done[0]),
    .dbg_state(d_st0)
  );

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_GAP(2)) u1 (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(d_rdy[1]), .bit_en(bit_en), .data_out(d_dout[1]),
    .out_valid(d_oval[1]), .busy(d_busy[1]), .word_done(d_done[1]),
    .dbg_state(d_st1)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- scoring ----------------
  task automatic cmp(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s u%0d t=%0t got %0h expected %0h", nm, k, $time, act, exp);
    end
  endtask

  // ---------------- model ----------------
  // Each word becomes a list of {valid,bit} slots; the model plays one slot
  // per strobe and signals word_done on the strobe after the list empties.
  logic [1:0] m_sl [2][0:15];
  int         m_len [2];
  int         m_pos [2];
  logic       m_hf [2], m_act [2], m_dout [2], m_oval [2], m_done [2];
  logic [7:0] m_hold [2];

  task automatic m_reset();
    for (int k = 0; k < 2; k++) begin
      m_hf[k] = 0; m_act[k] = 0; m_dout[k] = 0; m_oval[k] = 0; m_done[k] = 0;
      m_hold[k] = 0; m_len[k] = 0; m_pos[k] = 0;
    end
  endtask

  task automatic m_build(input int k, input logic [7:0] w);
    int n;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      m_sl[k][n] = {1'b1, (k == 0) ? w[7-i] : w[i]};
      n++;
    end
    if (PAR == 1) begin
      m_sl[k][n] = {1'b1, ^w};
      n++;
    end
    for (int g = 0; g < ((k == 0) ? 0 : 2); g++) begin
      m_sl[k][n] = 2'b00;
      n++;
    end
    m_len[k] = n;
    m_pos[k] = 0;
  endtask

  task automatic m_pop(input int k);
    {m_oval[k], m_dout[k]} = m_sl[k][m_pos[k]];
    m_pos[k]++;
  endtask

  task automatic m_step(input int k);
    logic take, dn, cons;
    take = in_valid && !m_hf[k];
    dn = 0;
    cons = 0;
    if (!m_act[k]) begin
      if (m_hf[k]) begin
        m_build(k, m_hold[k]); m_pop(k); m_act[k] = 1; cons = 1;
      end
    end else if (bit_en) begin
      if (m_pos[k] < m_len[k]) begin
        m_pop(k);
      end else begin
        dn = 1;
        if (m_hf[k]) begin
          m_build(k, m_hold[k]); m_pop(k); cons = 1;
        end else begin
          m_act[k] = 0; m_dout[k] = 0; m_oval[k] = 0;
        end
      end
    end
    m_done[k] = dn;
    if (cons) m_hf[k] = 0;
    if (take) begin
      m_hf[k] = 1;
      m_hold[k] = in_data;
    end
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) m_reset();
      else for (int k = 0; k < 2; k++) m_step(k);
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (check_en) begin
        for (int k = 0; k < 2; k++) begin
          cmp("data_out", k, 32'(d_dout[k]), 32'(m_dout[k]));
          cmp("out_valid", k, 32'(d_oval[k]), 32'(m_oval[k]));
          cmp("word_done", k, 32'(d_done[k]), 32'(m_done[k]));
          cmp("in_ready", k, 32'(d_rdy[k]), 32'(!m_hf[k]));
          cmp("busy", k, 32'(d_busy[k]), 32'(m_act[k] || m_hf[k]));
        end
      end
    end
  end

  // ---------------- stream recorder ----------------
  logic [2:0] rec0_q[$];
  logic [2:0] rec1_q[$];

  initial begin
    forever begin
      @(negedge clk);
      rec0_q.push_back({d_done[0], d_oval[0], d_dout[0]});
      rec1_q.push_back({d_done[1], d_oval[1], d_dout[1]});
    end
  end

  function automatic int rec_size(input int k);
    return (k == 0) ? rec0_q.size() : rec1_q.size();
  endfunction

  // fld: 0 = data_out, 1 = out_valid, 2 = word_done
  function automatic logic rec_fld(input int k, input int i, input int fld);
    logic [2:0] e;
    e = '0;
    if (i >= 0 && i < rec_size(k)) e = (k == 0) ? rec0_q[i] : rec1_q[i];
    return e[fld];
  endfunction

  function automatic int first_valid(input int k);
    for (int i = 0; i < rec_size(k); i++) if (rec_fld(k, i, 1)) return i;
    return -1;
  endfunction

  function automatic logic [31:0] pick(input int k, input int start, input int n, input int step, input int fld);
    logic [31:0] r;
    r = '0;
    for (int j = 0; j < n; j++) r = {r[30:0], rec_fld(k, start + j * step, fld)};
    return r;
  endfunction

  function automatic int count_fld(input int k, input int fld);
    int c;
    c = 0;
    for (int i = 0; i < rec_size(k); i++) if (rec_fld(k, i, fld)) c++;
    return c;
  endfunction

  task automatic rec_clear();
    rec0_q.delete();
    rec1_q.delete();
  endtask

  // ---------------- drivers ----------------
  task automatic send_word(input logic [7:0] w);
    logic ok;
    ok = 0;
    in_data = w;
    in_valid = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (d_rdy[0]) begin
        @(posedge clk);
        #1;
        ok = 1;
      end
    end
    in_valid = 1'b0;
    if (!ok) begin
      n_vec++;
      n_err++;
      $display("FAIL send_timeout word %0h not accepted", w);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string nm);
    for (int k = 0; k < 2; k++) begin
      cmp({nm, "_dout"}, k, 32'(d_dout[k]), 32'd0);
      cmp({nm, "_oval"}, k, 32'(d_oval[k]), 32'd0);
      cmp({nm, "_done"}, k, 32'(d_done[k]), 32'd0);
      cmp({nm, "_busy"}, k, 32'(d_busy[k]), 32'd0);
      cmp({nm, "_rdy"}, k, 32'(d_rdy[k]), 32'd1);
    end
  endtask

  // ---------------- stimulus ----------------
  int f0, f1;

  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    bit_en = 1'b1;
    #2 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    @(posedge clk);
    #2 reset = 1'b1;
    check_en = 1'b1;
    idle(2);

    // Single word 8'hD0.
    rec_clear();
    send_word(8'hD0);
    idle(30);
    f0 = first_valid(0);
    f1 = first_valid(1);
    cmp("d0_msb_bits", 0, pick(0, f0, 8, 1, 0), 32'hD0);
    cmp("d0_done_at_end", 0, 32'(rec_fld(0, f0 + 8 + PAR, 2)), 32'd1);
    cmp("d0_done_count", 0, 32'(count_fld(0, 2)), 32'd1);
    cmp("d0_lsb_bits", 1, pick(1, f1, 8, 1, 0), 32'h0B);

    // Back-to-back 8'hA5, 8'h3C.
    rec_clear();
    send_word(8'hA5);
    cmp("rdy_while_full", 0, 32'(d_rdy[0]), 32'd0);
    send_word(8'h3C);
    idle(40);
    f0 = first_valid(0);
`ifdef SERIALIZER_PARITY_EN
    cmp("b2b_bits", 0, pick(0, f0, 18, 1, 0), 32'h29478);
    cmp("b2b_valid", 0, pick(0, f0, 18, 1, 1), 32'h3FFFF);
`else
    cmp("b2b_bits", 0, pick(0, f0, 16, 1, 0), 32'hA53C);
    cmp("b2b_valid", 0, pick(0, f0, 16, 1, 1), 32'hFFFF);
`endif
    cmp("b2b_valid_after", 0, 32'(rec_fld(0, f0 + 16 + 2 * PAR, 1)), 32'd0);
    cmp("b2b_done_1", 0, 32'(rec_fld(0, f0 + 8 + PAR, 2)), 32'd1);
    cmp("b2b_done_2", 0, 32'(rec_fld(0, f0 + 16 + 2 * PAR, 2)), 32'd1);
    cmp("b2b_done_count", 0, 32'(count_fld(0, 2)), 32'd2);

    // Slot strobe every third edge, word 8'h81.
    rec_clear();
    send_word(8'h81);
    for (int i = 1; i <= 45; i++) begin
      bit_en = (i % 3 == 1);
      @(posedge clk);
      #1;
    end
    bit_en = 1'b1;
    idle(5);
    f0 = first_valid(0);
    cmp("slow_duration", 0, 32'(count_fld(0, 1)), 32'(24 + 3 * PAR));
    cmp("slow_bits", 0, pick(0, f0, 8, 3, 0), 32'h81);
    cmp("slow_hold", 0, pick(0, f0, 3, 1, 0), 32'h7);

`ifdef SERIALIZER_PARITY_EN
    // Parity plus gap: 8'h07 then 8'h01.
    rec_clear();
    send_word(8'h07);
    send_word(8'h01);
    idle(40);
    f0 = first_valid(0);
    f1 = first_valid(1);
    cmp("par_bits", 0, pick(0, f0, 18, 1, 0), 32'h01E03);
    cmp("par_gap_bits", 1, pick(1, f1, 22, 1, 0), 32'h382404);
    cmp("par_gap_valid", 1, pick(1, f1, 22, 1, 1), 32'h3FE7FC);
`endif

    // Reset during the 4th bit of 8'hFF with 8'h0F held.
    rec_clear();
    send_word(8'hFF);
    send_word(8'h0F);
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check_reset_vals("midreset");
    @(posedge clk);
    #2 reset = 1'b1;
    rec_clear();
    idle(30);
    cmp("no_done_after_reset", 0, 32'(count_fld(0, 2)), 32'd0);
    cmp("no_done_after_reset", 1, 32'(count_fld(1, 2)), 32'd0);
    cmp("no_data_after_reset", 0, 32'(count_fld(0, 1)), 32'd0);
    rec_clear();
    send_word(8'h5A);
    idle(30);
    f0 = first_valid(0);
    cmp("post_reset_bits", 0, pick(0, f0, 8, 1, 0), 32'h5A);
    cmp("post_reset_done", 0, 32'(count_fld(0, 2)), 32'd1);

    // LSB-first word 8'h0B.
    rec_clear();
    send_word(8'h0B);
    idle(30);
    f0 = first_valid(0);
    f1 = first_valid(1);
    cmp("0b_msb_bits", 0, pick(0, f0, 8, 1, 0), 32'h0B);
    cmp("0b_lsb_bits", 1, pick(1, f1, 8, 1, 0), 32'hD0);
    cmp("0b_gap_valid", 1, pick(1, f1, 8 + PAR + 2, 1, 1), (PAR == 1) ? 32'h7FC : 32'h3FC);

    idle(3);
    check_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bit_serializer.md
# bit_serializer

Parallel-to-serial front end for the bit-pattern detector. Accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per paced slot on a registered serial output that drives the detector's serial data input directly. A one-word holding register allows gap-free back-to-back streaming. Idle and gap slots drive 0, so the detector sees a clean zero background between words.

## Interface
- WIDTH, 8: bits per word; must be at least 2.
- MSB_FIRST, 1: 1 transmits bit WIDTH-1 first; 0 transmits bit 0 first.
- IDLE_GAP, 0: number of zero slots inserted after each word (0–15).
- clk  input  1  single clock; all logic on posedge.
- reset  input  1  asynchronous, active-low reset (asserts on negedge; 0 = in reset).
- in_data  input  WIDTH  word to send.
- in_valid  input  1  in_data valid.
- in_ready  output  1  holding register empty; transfer on posedge when in_valid && in_ready.
- bit_en  input  1  slot strobe; the serial output advances only on edges where it is 1. Tie to 1 for one bit per clock.
- data_out  output  1  serial bit; registered.
- out_valid  output  1  data_out carries a data or parity bit.
- busy  output  1  FSM not in IDLE, or holding register full.
- word_done  output  1  one-cycle pulse after the final slot of a word ends.

## Operation
- Reset values:
  - data_out=0, out_valid=0, word_done=0, busy=0, in_ready=1.
  - Holding register empty; shift register 0; bit counter 0; state IDLE.
- Handshake:
  - in_ready = ~hold_full.
  - A transfer sets hold_full and captures in_data.
  - in_data is ignored when in_ready=0.
- FSM states are IDLE, SHIFT, PAR, GAP.
  - IDLE: on the first edge with hold_full=1, load the shift register from the holding register, clear hold_full, drive the first bit, set out_valid=1, and go to SHIFT. This load does not wait for bit_en.
  - SHIFT, on a bit_en edge with cnt<WIDTH-1: shift, cnt++, drive the next bit.
  - SHIFT, on a bit_en edge with cnt==WIDTH-1: go to PAR if enabled; otherwise to GAP if IDLE_GAP>0; otherwise finish.
  - PAR: data_out = parity bit for one slot, then GAP or finish.
  - GAP: data_out=0, out_valid=0 for IDLE_GAP slots, then finish.
  - Finish: pulse word_done. If hold_full=1, reload immediately on the same edge and stay in SHIFT with no dead slot. Otherwise go to IDLE with data_out=0 and out_valid=0.
- Simultaneous transfer and reload on one edge: the reload takes the old holding contents, and the new word is captured into the now-free holding register.
- Bit counter width is $clog2(WIDTH). The gap counter is 4 bits and saturates at IDLE_GAP.
- Reset mid-word: the word is discarded, and the holding register contents are lost. No word_done is produced for the aborted word.

## Timing
- Transfer at edge N, FSM in IDLE: the first bit is valid after edge N+1. Each following bit is valid after the next bit_en edge.
- With bit_en=1, no parity and IDLE_GAP=0, one word occupies exactly WIDTH cycles. Continuous supply gives 100% slot occupancy.
- word_done is high for the cycle after the edge that ends the last slot, i.e. the parity slot, the last gap slot, or otherwise the last data bit.
- bit_en=0 holds data_out, out_valid and all counters. A held data_out is stable for the detector.

## Configuration
- SERIALIZER_PARITY_EN defined: the PAR state is compiled in. One even-parity bit (XOR of the WIDTH data bits) is appended as a slot with out_valid=1.
- SERIALIZER_PARITY_EN undefined: the PAR state and parity logic are absent. SHIFT goes directly to GAP or finish.

## Structure
- Package bit_serializer_pkg holds:
  - the state enum typedef (IDLE, SHIFT, PAR, GAP);
  - the 4-bit gap-counter width constant.
- One sub-module, serializer_hold_reg, contains the holding register, the hold_full flag, the in_ready logic and the take strobe.
- The FSM and shift register stay in bit_serializer.

## Test plan
- Reset, then WIDTH=8, MSB_FIRST=1, bit_en=1; send 8'hD0 -> data_out 1,1,0,1,0,0,0,0 on cycles N+1..N+8. word_done is seen on the cycle after the eighth bit (N+9). The detector output pulses once.
- Back-to-back words 8'hA5 then 8'h3C, both presented early -> 16 contiguous valid bits with no gap. word_done pulses at the 8-bit and 16-bit boundaries. in_ready drops while the holding register is full.
- bit_en asserted every 3rd cycle, word 8'h81 -> each bit held 3 cycles. Total duration 24 cycles from the first bit.
- SERIALIZER_PARITY_EN defined, IDLE_GAP=2, words 8'h07 then 8'h01:
  - 8'h07 -> eight data bits, parity 1, then two 0 slots with out_valid=0;
  - 8'h01 -> eight data bits, parity 1, then two 0 slots with out_valid=0.
- Reset asserted at the 4th bit of 8'hFF, with 8'h0F in the holding register -> all outputs at reset values, in_ready=1. No word_done. The next accepted word streams normally.
- MSB_FIRST=0, word 8'h0B -> data_out 1,1,0,1,0,0,0,0.
